// File: rtl/spad_filter_pkg.sv
// rtl/spad_filter_pkg.sv - shared constants, default command layout and width helpers for spad_inst_filter
package spad_filter_pkg;

  localparam logic [14:0] MATCH_OPC_DEFAULT = 15'h3003;
  localparam logic [31:0] NOP_INST_DEFAULT  = 32'h00008093;

  function automatic int spadChW(input int numCh);
    return (numCh <= 2) ? 1 : $clog2(numCh);
  endfunction

  function automatic int spadSizeW(input int instW, input int chW);
    return instW - 16 - chW;
  endfunction

  localparam int CH_W_DEFAULT   = spadChW(2);
  localparam int SIZE_W_DEFAULT = spadSizeW(32, CH_W_DEFAULT);

  // Queued command layout for the default 32-bit, two-channel configuration
  typedef struct packed {
    logic [CH_W_DEFAULT-1:0]   ch;
    logic [SIZE_W_DEFAULT-1:0] size;
    logic                      repl;
  } cmd_t;

endpackage

// File: rtl/spad_cmd_fifo.sv
// rtl/spad_cmd_fifo.sv - synchronous command FIFO with registered occupancy count
module spad_cmd_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Push,
  input  logic [W-1:0]  PushData,
  input  logic          Pop,
  output logic [W-1:0]  PopData,
  output logic          Full,
  output logic          Empty,
  output logic [AW:0]   Count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  // Full is taken from the registered count, so a same-cycle pop never frees room for a push
  assign Full    = (Count == (AW+1)'(DEPTH));
  assign Empty   = (Count == '0);
  assign doPush  = Push && !Full;
  assign doPop   = Pop && !Empty;
  assign PopData = mem[rdPtr];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   Count <= Count + (AW+1)'(1);
        2'b01:   Count <= Count - (AW+1)'(1);
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr] <= PushData;
  end

endmodule

// File: rtl/spad_inst_filter.sv
// rtl/spad_inst_filter.sv - replaces scratchpad command instructions with NOPs and queues them per channel
// Optional statistics counters: SPAD_FILTER_STATS_EN
module spad_inst_filter
  import spad_filter_pkg::*;
#(
  parameter int          INST_W     = 32,
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          NOP_CYCLES = 1,
  parameter logic [14:0] MATCH_OPC  = MATCH_OPC_DEFAULT,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT,
  localparam int         CH_W       = spadChW(NUM_CH),
  localparam int         SIZE_W     = spadSizeW(INST_W, CH_W)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InInstRespValid,
  input  logic [INST_W-1:0] InInstRespData,
  output logic              OutInstRespValid,
  output logic [INST_W-1:0] OutInstRespData,
  output logic              ReplayReq,
  output logic [NUM_CH-1:0] SpCmdValid,
  input  logic [NUM_CH-1:0] SpCmdReady,
  output logic [SIZE_W-1:0] SpCmdSize,
  output logic              SpCmdRepl,
  output logic              FifoFull
`ifdef SPAD_FILTER_STATS_EN
  ,
  output logic [31:0]       StatMatched,
  output logic [31:0]       StatSquashed
`endif
);

  localparam logic [INST_W-1:0] NOP_W      = INST_W'(NOP_INST);
  localparam logic [2:0]        SHADOW_LEN = 3'(NOP_CYCLES);
  localparam logic [0:0]        ST_IDLE    = 1'b0;
  localparam logic [0:0]        ST_SHADOW  = 1'b1;
  localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [SIZE_W-1:0] size;
    logic              repl;
  } cmdEntry_t;

  logic [2:0]        shadowCnt, shadowCntNext;
  logic [0:0]        state;
  logic              inCmd, push, pop, fifoFull, fifoEmpty;
  logic              pushedLastCycle, headVisible;
  logic              outValidNext, replayNext;
  logic [INST_W-1:0] outDataNext;
  logic [CNT_W-1:0]  fifoCount;
  cmdEntry_t         inEntry, headEntry;

  assign inEntry.ch   = InInstRespData[15 +: CH_W];
  assign inEntry.size = InInstRespData[INST_W-2 -: SIZE_W];
  assign inEntry.repl = InInstRespData[INST_W-1];
  assign inCmd = InInstRespValid && (InInstRespData[14:0] == MATCH_OPC)
                 && (32'(inEntry.ch) < NUM_CH);
  assign state = (shadowCnt == 3'd0) ? ST_IDLE : ST_SHADOW;

  always_comb begin
    shadowCntNext = shadowCnt;
    outValidNext  = InInstRespValid;
    outDataNext   = InInstRespData;
    replayNext    = 1'b0;
    push          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inCmd && !fifoFull) begin
          push          = 1'b1;
          outValidNext  = 1'b1;
          outDataNext   = NOP_W;
          shadowCntNext = SHADOW_LEN;
        end else if (inCmd) begin
          outValidNext = 1'b0;
          outDataNext  = '0;
          replayNext   = 1'b1;
        end
      end
      default: begin
        // Only delivered responses advance the shadow
        if (!InInstRespValid) begin
          outValidNext = 1'b0;
          outDataNext  = NOP_W;
        end else begin
          shadowCntNext = shadowCnt - 3'd1;
          outValidNext  = !inCmd;
          outDataNext   = inCmd ? '0 : NOP_W;
          replayNext    = inCmd;
        end
      end
    endcase
  end

  spad_cmd_fifo #(
    .W     ($bits(cmdEntry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .Push     (push),
    .PushData (inEntry),
    .Pop      (pop),
    .PopData  (headEntry),
    .Full     (fifoFull),
    .Empty    (fifoEmpty),
    .Count    (fifoCount)
  );

  // A lone entry written on the previous edge stays hidden one cycle so it trails its NOP
  assign headVisible = !fifoEmpty && !(pushedLastCycle && fifoCount == CNT_W'(1));

  always_comb begin
    SpCmdValid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      SpCmdValid[i] = headVisible && (32'(headEntry.ch) == i);
    end
  end

  assign pop       = |(SpCmdValid & SpCmdReady);
  assign SpCmdSize = headVisible ? headEntry.size : '0;
  assign SpCmdRepl = headVisible && headEntry.repl;
  assign FifoFull  = fifoFull;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadowCnt        <= 3'd0;
      OutInstRespValid <= 1'b0;
      OutInstRespData  <= '0;
      ReplayReq        <= 1'b0;
      pushedLastCycle  <= 1'b0;
    end else begin
      shadowCnt        <= shadowCntNext;
      OutInstRespValid <= outValidNext;
      OutInstRespData  <= outDataNext;
      ReplayReq        <= replayNext;
      pushedLastCycle  <= push;
    end
  end

`ifdef SPAD_FILTER_STATS_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      StatMatched  <= '0;
      StatSquashed <= '0;
    end else begin
      if (push && StatMatched != '1)        StatMatched  <= StatMatched + 32'd1;
      if (replayNext && StatSquashed != '1) StatSquashed <= StatSquashed + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_spad_inst_filter.sv
// tb/tb_spad_inst_filter.sv - scoreboard bench for spad_inst_filter (default parameters)
module tb_spad_inst_filter;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00008093;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        InInstRespValid = 1'b0;
  logic [31:0] InInstRespData = '0;
  logic        OutInstRespValid;
  logic [31:0] OutInstRespData;
  logic        ReplayReq;
  logic [1:0]  SpCmdValid;
  logic [1:0]  SpCmdReady = '0;
  logic [14:0] SpCmdSize;
  logic        SpCmdRepl;
  logic        FifoFull;
`ifdef SPAD_FILTER_STATS_EN
  logic [31:0] StatMatched;
  logic [31:0] StatSquashed;
`endif

  spad_inst_filter dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .InInstRespValid  (InInstRespValid),
    .InInstRespData   (InInstRespData),
    .OutInstRespValid (OutInstRespValid),
    .OutInstRespData  (OutInstRespData),
    .ReplayReq        (ReplayReq),
    .SpCmdValid       (SpCmdValid),
    .SpCmdReady       (SpCmdReady),
    .SpCmdSize        (SpCmdSize),
    .SpCmdRepl        (SpCmdRepl),
    .FifoFull         (FifoFull)
`ifdef SPAD_FILTER_STATS_EN
    ,
    .StatMatched      (StatMatched),
    .StatSquashed     (StatSquashed)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct { logic valid; logic [31:0] data; logic replay; } resp_t;
  typedef struct { logic [0:0] ch; logic [14:0] size; logic repl; } mcmd_t;

  resp_t respQ[$];
  mcmd_t cmdQ[$];
  int    mCnt = 0;
  bit    mPushedLast = 0;
  int    mMatched = 0;
  int    mSquashed = 0;
  logic [1:0] ready = '0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkCmd(input logic [0:0] ch, input logic [14:0] size, input logic repl);
    return {repl, size, ch, 15'h3003};
  endfunction

  // One cycle: check what the last edge produced, then drive the next input and predict it
  task automatic step(input logic v, input logic [31:0] d);
    resp_t r;
    mcmd_t c;
    bit    isCmd, full, vis, popNow, pushNow;
    logic [1:0] expV;
    @(negedge Clock);
    if (respQ.size() > 0) begin
      r = respQ.pop_front();
      chk("out_valid", 64'(OutInstRespValid), 64'(r.valid));
      chk("out_data", 64'(OutInstRespData), 64'(r.data));
      chk("replay", 64'(ReplayReq), 64'(r.replay));
    end
    vis  = cmdQ.size() > 0 && !(mPushedLast && cmdQ.size() == 1);
    expV = vis ? (2'b01 << cmdQ[0].ch) : 2'b00;
    chk("sp_valid", 64'(SpCmdValid), 64'(expV));
    chk("fifo_full", 64'(FifoFull), 64'(cmdQ.size() == DEPTH));
    if (vis) begin
      chk("sp_size", 64'(SpCmdSize), 64'(cmdQ[0].size));
      chk("sp_repl", 64'(SpCmdRepl), 64'(cmdQ[0].repl));
    end
    popNow = vis && ready[cmdQ[0].ch];

    InInstRespValid = v;
    InInstRespData  = d;
    SpCmdReady      = ready;
    isCmd   = v && d[14:0] == 15'h3003;
    full    = cmdQ.size() == DEPTH;
    pushNow = 0;
    r.valid = v; r.data = d; r.replay = 0;
    if (mCnt == 0) begin
      if (isCmd && !full) begin
        pushNow = 1; r.valid = 1; r.data = NOP; mCnt = 1;
      end else if (isCmd) begin
        r.valid = 0; r.data = '0; r.replay = 1;
      end
    end else if (!v) begin
      r.valid = 0; r.data = NOP;
    end else begin
      mCnt--;
      if (isCmd) begin r.valid = 0; r.data = '0; r.replay = 1; end
      else begin r.valid = 1; r.data = NOP; end
    end
    if (r.replay) mSquashed++;
    if (popNow) void'(cmdQ.pop_front());
    if (pushNow) begin
      c.ch = d[15]; c.size = d[30:16]; c.repl = d[31];
      cmdQ.push_back(c);
      mMatched++;
    end
    mPushedLast = pushNow;
    respQ.push_back(r);
  endtask

  task automatic checkResetOutputs();
    chk("rst_out_valid", 64'(OutInstRespValid), 64'd0);
    chk("rst_out_data", 64'(OutInstRespData), 64'd0);
    chk("rst_replay", 64'(ReplayReq), 64'd0);
    chk("rst_sp_valid", 64'(SpCmdValid), 64'd0);
    chk("rst_sp_size", 64'(SpCmdSize), 64'd0);
    chk("rst_sp_repl", 64'(SpCmdRepl), 64'd0);
    chk("rst_fifo_full", 64'(FifoFull), 64'd0);
`ifdef SPAD_FILTER_STATS_EN
    chk("rst_stat_matched", 64'(StatMatched), 64'd0);
    chk("rst_stat_squashed", 64'(StatSquashed), 64'd0);
`endif
  endtask

  task automatic doReset();
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checkResetOutputs();
    respQ.delete();
    cmdQ.delete();
    mCnt = 0; mPushedLast = 0; mMatched = 0; mSquashed = 0;
    InInstRespValid = 1'b0;
    InInstRespData  = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge Clock);
    checkResetOutputs();
    Reset = 1'b1;

    // pass-through and a single command on channel 0
    ready = 2'b00;
    step(1'b1, 32'h00000013);
    step(1'b1, 32'h80053003);
    idle(2);
    ready = 2'b10;
    idle(2);
    ready = 2'b01;
    idle(3);

    // shadow: following response forced to NOP, third passes; idle inside shadow holds it
    step(1'b1, mkCmd(1'b1, 15'h0123, 1'b0));
    step(1'b1, 32'h00000013);
    step(1'b1, 32'h00000093);
    step(1'b1, mkCmd(1'b0, 15'h7FFF, 1'b1));
    step(1'b0, 32'hDEADBEEF);
    step(1'b1, 32'h00000013);
    step(1'b1, 32'h00000113);
    ready = 2'b11;
    idle(4);

    // fill the FIFO, squash a fifth command and a command inside the shadow, then drain
    ready = 2'b00;
    step(1'b1, mkCmd(1'b0, 15'h0001, 1'b1));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b1, 15'h0002, 1'b0));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b0, 15'h0003, 1'b1));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b1, 15'h0004, 1'b0));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b0, 15'h0005, 1'b1));
    step(1'b1, 32'h00000013);
    ready = 2'b11;
    idle(6);
    step(1'b1, mkCmd(1'b1, 15'h0011, 1'b1));
    step(1'b1, mkCmd(1'b0, 15'h0022, 1'b0));
    idle(3);

    // random mix of commands, non-commands, bubbles and backpressure
    for (int i = 0; i < 300; i++) begin
      ready = 2'($urandom);
      if ($urandom_range(0, 9) < 4) begin
        d = mkCmd(1'($urandom), 15'($urandom), 1'($urandom));
      end else begin
        d = $urandom;
        if (d[14:0] == 15'h3003) d[0] = ~d[0];
      end
      step($urandom_range(0, 9) < 7, d);
    end
    ready = 2'b11;
    idle(8);

    // reset mid-operation with three entries queued and the shadow live
    ready = 2'b00;
    step(1'b1, mkCmd(1'b0, 15'h0100, 1'b1));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b1, 15'h0200, 1'b0));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b0, 15'h0300, 1'b1));
    @(negedge Clock);
    doReset();
    step(1'b1, 32'h00000013);
    idle(2);

    // three accepted, two squashed
    step(1'b1, mkCmd(1'b0, 15'h0010, 1'b0));
    step(1'b1, mkCmd(1'b1, 15'h0020, 1'b0));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b1, 15'h0030, 1'b1));
    step(1'b1, mkCmd(1'b0, 15'h0040, 1'b1));
    step(1'b1, 32'h00000013);
    step(1'b1, mkCmd(1'b0, 15'h0050, 1'b0));
    idle(2);
`ifdef SPAD_FILTER_STATS_EN
    chk("stat_matched", 64'(StatMatched), 64'd3);
    chk("stat_squashed", 64'(StatSquashed), 64'd2);
    chk("stat_matched_model", 64'(StatMatched), 64'(mMatched));
    chk("stat_squashed_model", 64'(StatSquashed), 64'(mSquashed));
`endif
    ready = 2'b11;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
